// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the instruction/data memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Latched-request field widths; keep equal to the arbiter's WORD_SIZE/ADDR_BITS.
  localparam int c_WORD_SIZE = 16;
  localparam int c_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } ArbState;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } ArbOwner;

  typedef struct packed {
    logic [c_ADDR_BITS-1:0] addr;
    logic [c_WORD_SIZE-1:0] wdata;
    logic                   write;
    ArbOwner                owner;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_starve_ctr
// Purpose  : Saturating count of data grants made while a fetch is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic instr_req,
  input  logic instr_grant,
  input  logic data_grant,
  output logic starved
);

  localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

  logic [c_CW-1:0] r_starve_cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_starve_cnt <= '0;
    end else if (!instr_req || instr_grant) begin
      r_starve_cnt <= '0;
    end else if (data_grant && (r_starve_cnt != c_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign starved = (r_starve_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency RAM between fetch and load/store ports.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE    = c_WORD_SIZE,
  parameter int ADDR_BITS    = c_ADDR_BITS,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 InstrReq,
  input  logic [ADDR_BITS-1:0] InstrAddr,
  output logic [WORD_SIZE-1:0] InstrIn,
  output logic                 InstrDone,
  input  logic                 ReadData,
  input  logic                 WriteData,
  input  logic [ADDR_BITS-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  output logic [ADDR_BITS-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] MemRData,
  output logic [1:0]           Owner
);

  localparam int                 c_CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LATENCY - 1);

  ArbState            r_state;
  logic [c_CNT_W-1:0] r_cnt;
  mem_req_t           r_req;
  ArbOwner            r_owner;
  logic               r_mem_read;
  logic               r_mem_write;

  logic w_data_req;
  logic w_starved;
  logic w_grant_data;
  logic w_grant_instr;
  logic w_done_instr;
  logic w_done_data;

  assign w_data_req    = ReadData | WriteData;
  // Data normally wins; a fetch that has waited through STARVE_LIMIT data grants takes the next slot.
  assign w_grant_data  = (r_state == ARB_IDLE) && w_data_req && !(InstrReq && w_starved);
  assign w_grant_instr = (r_state == ARB_IDLE) && InstrReq && (!w_data_req || w_starved);

  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .instr_req   (InstrReq),
    .instr_grant (w_grant_instr),
    .data_grant  (w_grant_data),
    .starved     (w_starved)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ARB_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_owner     <= OWN_NONE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_data || w_grant_instr) begin
            r_req.addr  <= w_grant_data ? DataAddr : InstrAddr;
            r_req.wdata <= w_grant_data ? DataOut : '0;
            r_req.write <= w_grant_data && WriteData;
            r_req.owner <= w_grant_data ? OWN_DATA : OWN_INSTR;
            r_owner     <= w_grant_data ? OWN_DATA : OWN_INSTR;
            r_cnt       <= '0;
            // Strobe is registered here so it is high exactly for the cnt==0 BUSY cycle.
            r_mem_read  <= !(w_grant_data && WriteData);
            r_mem_write <= w_grant_data && WriteData;
            r_state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= ARB_IDLE;
        end
        default: begin
          r_owner <= OWN_NONE;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign w_done_instr = (r_state == ARB_DONE) && (r_req.owner == OWN_INSTR);
  assign w_done_data  = (r_state == ARB_DONE) && (r_req.owner == OWN_DATA);

  assign MemAddr   = (r_state == ARB_BUSY) ? r_req.addr  : '0;
  assign MemWData  = (r_state == ARB_BUSY) ? r_req.wdata : '0;
  assign MemRead   = r_mem_read;
  assign MemWrite  = r_mem_write;
  assign Owner     = r_owner;

  assign InstrIn   = w_done_instr ? MemRData : '0;
  assign DataIn    = (w_done_data && !r_req.write) ? MemRData : '0;
  // Idle-high handshake: the core stalls only while its own request is outstanding.
  assign InstrDone = Resetn && (!InstrReq || w_done_instr);
  assign DataDone  = Resetn && (!w_data_req || w_done_data);

endmodule
`default_nettype wire
